// File: rtl/serial_subtractor_clk.sv
// serial_subtractor_clk: bit-serial a - b - b_in, one full-subtractor cell, LSB first,
// with valid/ready handshakes on both sides.
module serial_subtractor_clk #(
   parameter int WIDTH = 4
) (
   input  logic             iClk,
   input  logic             iRstN,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             b_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             b_out,
   output logic             busy
);
   localparam int CNT_W = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, diff_q, diff_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               br_q, br_d, b_out_q, b_out_d;
   logic               d_i, br_n;

   // The minuend register doubles as the result register: each difference bit
   // enters at the MSB as the consumed operand bit leaves at the LSB.
   always_comb begin
      d_i     = a_q[0] ^ b_q[0] ^ br_q;
      br_n    = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      br_d    = br_q;
      cnt_d   = cnt_q;
      diff_d  = diff_q;
      b_out_d = b_out_q;
      case (state_q)
         IDLE: if (in_valid) begin
            a_d     = a;
            b_d     = b;
            br_d    = b_in;
            cnt_d   = '0;
            state_d = RUN;
         end
         RUN: begin
            a_d   = {d_i, a_q[WIDTH-1:1]};
            b_d   = {1'b0, b_q[WIDTH-1:1]};
            br_d  = br_n;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               diff_d  = {d_i, a_q[WIDTH-1:1]};
               b_out_d = br_n;
               state_d = DONE;
            end
         end
         DONE: state_d = out_ready ? IDLE : DONE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         br_q    <= 1'b0;
         cnt_q   <= '0;
         diff_q  <= '0;
         b_out_q <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         br_q    <= br_d;
         cnt_q   <= cnt_d;
         diff_q  <= diff_d;
         b_out_q <= b_out_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q == RUN);
   assign diff      = diff_q;
   assign b_out     = b_out_q;
endmodule

// File: tb/tb_serial_subtractor_clk.sv
// tb_serial_subtractor_clk: table vectors, hand-written corner sequences and an
// exhaustive sweep against an arithmetic reference model.
module tb_serial_subtractor_clk;
   localparam int W = 4;

   logic         iClk = 1'b0, iRstN = 1'b0;
   logic         in_valid = 1'b0, out_ready = 1'b0, b_in = 1'b0;
   logic [W-1:0] a = '0, b = '0;
   logic         in_ready, out_valid, busy, b_out;
   logic [W-1:0] diff;

   int checks = 0, errors = 0;

   serial_subtractor_clk #(.WIDTH(W)) dut (
      .iClk(iClk), .iRstN(iRstN), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .b_in(b_in), .out_valid(out_valid), .out_ready(out_ready),
      .diff(diff), .b_out(b_out), .busy(busy)
   );

   always #5 iClk = ~iClk;

   typedef struct {
      logic [W-1:0] a, b;
      logic         bin;
      logic [W-1:0] d;
      logic         bo;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Unsigned a - b - b_in reduced mod 2^(W+1): {b_out, diff}.
   function automatic logic [W:0] model(input logic [W-1:0] ma, mb, input logic mbin);
      int r;
      r = int'(ma) - int'(mb) - int'(mbin);
      return (W+1)'(r);
   endfunction

   task automatic wait_idle();
      int n = 0;
      while (!in_ready && n < 30) begin
         @(negedge iClk);
         n++;
      end
      chk("accept_ready", 32'(in_ready), 1);
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (!out_valid && n < 20) begin
         @(negedge iClk);
         n++;
      end
   endtask

   // Full transaction; rnd applies random backpressure in DONE.
   task automatic txn(input logic [W-1:0] ta, tb, input logic tbin, input bit rnd,
                      output logic [W-1:0] rd, output logic rbo);
      int n;
      wait_idle();
      a = ta; b = tb; b_in = tbin; in_valid = 1'b1;
      @(negedge iClk);
      in_valid = 1'b0; a = W'($urandom); b = W'($urandom); b_in = 1'($urandom);
      chk("busy_after_accept", 32'(busy), 1);
      wait_done(n);
      chk("latency", 32'(n), W);
      rd = diff; rbo = b_out;
      n = 0;
      do begin
         chk("hold_result", 32'({b_out, diff}), 32'({rbo, rd}));
         out_ready = (rnd && n < 8) ? 1'($urandom_range(0, 1)) : 1'b1;
         @(negedge iClk);
         n++;
      end while (out_valid && n < 20);
      out_ready = 1'b0;
      chk("idle_after_hs", 32'({in_ready, out_valid, busy}), 32'(3'b100));
   endtask

   initial begin
      vec_t         v[4];
      logic [W-1:0] rd;
      logic         rbo;
      logic [W:0]   exp;
      int           n, pulses;
      logic         prev_ov;

      v[0] = '{4'd9,  4'd3,  1'b0, 4'h6, 1'b0};
      v[1] = '{4'd3,  4'd9,  1'b0, 4'hA, 1'b1};
      v[2] = '{4'd5,  4'd5,  1'b1, 4'hF, 1'b1};
      v[3] = '{4'd0,  4'd15, 1'b1, 4'h0, 1'b1};

      #1;
      chk("rst_state", 32'({in_ready, out_valid, busy}), 32'(3'b100));
      chk("rst_result", 32'({b_out, diff}), 0);
      @(negedge iClk);
      iRstN = 1'b1;

      for (int i = 0; i < 4; i++) begin
         txn(v[i].a, v[i].b, v[i].bin, 1'b0, rd, rbo);
         chk($sformatf("vec%0d_diff", i), 32'(rd), 32'(v[i].d));
         chk($sformatf("vec%0d_bout", i), 32'(rbo), 32'(v[i].bo));
      end

      // Backpressure: result must hold while out_ready stays low.
      wait_idle();
      a = 4'd12; b = 4'd4; b_in = 1'b0; in_valid = 1'b1;
      @(negedge iClk);
      in_valid = 1'b0;
      wait_done(n);
      for (int k = 0; k < 10; k++) begin
         chk("bp_hold", 32'({out_valid, in_ready, b_out, diff}), 32'({1'b1, 1'b0, 1'b0, 4'd8}));
         @(negedge iClk);
      end
      out_ready = 1'b1;
      @(negedge iClk);
      out_ready = 1'b0;
      chk("bp_release", 32'({in_ready, out_valid}), 32'(2'b10));

      // Inputs driven during RUN must be ignored; one result pulse only.
      a = 4'd7; b = 4'd2; b_in = 1'b0; in_valid = 1'b1;
      @(negedge iClk);
      a = 4'd1; b = 4'd1;
      pulses = 0; prev_ov = 1'b0; n = 0;
      while (n < 14) begin
         if (out_valid && !prev_ov) begin
            pulses++;
            chk("busy_ignore_res", 32'({b_out, diff}), 32'({1'b0, 4'd5}));
            in_valid = 1'b0;
            out_ready = 1'b1;
         end
         prev_ov = out_valid;
         if (in_valid) begin a = ~a; b = ~b; end
         @(negedge iClk);
         n++;
      end
      out_ready = 1'b0;
      chk("busy_ignore_pulses", 32'(pulses), 1);

      // Asynchronous reset two RUN edges into a transaction.
      wait_idle();
      a = 4'd10; b = 4'd1; b_in = 1'b0; in_valid = 1'b1;
      @(negedge iClk);
      in_valid = 1'b0;
      @(negedge iClk);
      chk("mid_busy", 32'(busy), 1);
      #2 iRstN = 1'b0;
      #1;
      chk("mid_rst_state", 32'({in_ready, out_valid, busy}), 32'(3'b100));
      chk("mid_rst_result", 32'({b_out, diff}), 0);
      @(negedge iClk);
      iRstN = 1'b1;
      txn(4'd4, 4'd4, 1'b0, 1'b0, rd, rbo);
      chk("post_rst_res", 32'({rbo, rd}), 0);

      // Exhaustive sweep with random backpressure.
      for (int i = 0; i < 512; i++) begin
         txn(W'(i >> 5), W'(i >> 1), i[0], 1'b1, rd, rbo);
         exp = model(W'(i >> 5), W'(i >> 1), i[0]);
         chk($sformatf("sweep_%0d", i), 32'({rbo, rd}), 32'(exp));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
